// File: rtl/exc_ctrl_if.sv
// Handshake bundle between the MEM-stage exception encoder/CP0/PC mux and exc_ctrl.
// The slave modport is the controller's view; master is the pipeline side.
interface exc_ctrl_if;
    logic [31:0] except_type;
    logic [31:0] pc_m;
    logic [31:0] bad_addr_m;
    logic        in_delayslot_m;
    logic        stall_m;
    logic [31:0] cp0_epc;

    logic        flush;
    logic        pc_redirect;
    logic [31:0] new_pc;
    logic        exc_we;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic        badvaddr_we;
    logic [31:0] exc_badvaddr;
    logic        eret_we;
    logic        busy;

    modport slave (
        input  except_type, pc_m, bad_addr_m, in_delayslot_m, stall_m, cp0_epc,
        output flush, pc_redirect, new_pc, exc_we, exc_code, exc_bd, exc_epc,
               badvaddr_we, exc_badvaddr, eret_we, busy
    );

    modport master (
        output except_type, pc_m, bad_addr_m, in_delayslot_m, stall_m, cp0_epc,
        input  flush, pc_redirect, new_pc, exc_we, exc_code, exc_bd, exc_epc,
               badvaddr_we, exc_badvaddr, eret_we, busy
    );
endinterface

// File: rtl/exc_ctrl.sv
// Precise-exception commit sequencer: capture in MEM, wait out stalls, issue a
// one-cycle commit (CP0 write, flush, PC redirect), then hold off new exceptions.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_HOLD} state_t;

    localparam logic [2:0] HOLD_LOAD = 3'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [3:0]  r_type;
    logic [31:0] r_pc;
    logic [31:0] r_bad;
    logic        r_bd;
    logic [31:0] r_cp0_epc;

    logic        w_valid;
    logic        w_idle;
    logic        w_commit_go;
    logic [3:0]  w_type;
    logic [31:0] w_pc;
    logic [31:0] w_bad;
    logic        w_bd;
    logic [31:0] w_cp0_epc;
    logic        w_eret;
    logic [4:0]  w_code;
    logic [31:0] w_epc_val;
    logic        w_bv_we;
    logic [31:0] w_bv;

    always_comb begin
        w_valid = 1'b0;
        if (bus.except_type[31:4] == 28'd0) begin
            case (bus.except_type[3:0])
                4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'ha, 4'hc, 4'he: w_valid = 1'b1;
                default:                                          w_valid = 1'b0;
            endcase
        end
    end

    // Commit straight out of IDLE uses live inputs; out of WAIT the frozen copy.
    assign w_idle      = (r_state == S_IDLE);
    assign w_type      = w_idle ? bus.except_type[3:0] : r_type;
    assign w_pc        = w_idle ? bus.pc_m             : r_pc;
    assign w_bad       = w_idle ? bus.bad_addr_m       : r_bad;
    assign w_bd        = w_idle ? bus.in_delayslot_m   : r_bd;
    assign w_cp0_epc   = w_idle ? bus.cp0_epc          : r_cp0_epc;
    assign w_commit_go = !bus.stall_m && ((w_idle && w_valid) || (r_state == S_WAIT));

    assign w_eret    = (w_type == 4'he);
    assign w_code    = (w_type == 4'h1) ? 5'd0 : {1'b0, w_type};
    assign w_epc_val = w_bd ? (w_pc - 32'd4) : w_pc;
    assign w_bv_we   = (w_type == 4'h4) || (w_type == 4'h5);
    // A misaligned PC on AdEL means the fetch itself faulted.
    assign w_bv      = ((w_type == 4'h4) && (w_pc[1:0] != 2'b00)) ? w_pc : w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= 3'd0;
            r_type           <= 4'd0;
            r_pc             <= 32'd0;
            r_bad            <= 32'd0;
            r_bd             <= 1'b0;
            r_cp0_epc        <= 32'd0;
            bus.flush        <= 1'b0;
            bus.pc_redirect  <= 1'b0;
            bus.new_pc       <= 32'd0;
            bus.exc_we       <= 1'b0;
            bus.exc_code     <= 5'd0;
            bus.exc_bd       <= 1'b0;
            bus.exc_epc      <= 32'd0;
            bus.badvaddr_we  <= 1'b0;
            bus.exc_badvaddr <= 32'd0;
            bus.eret_we      <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.flush       <= 1'b0;
            bus.pc_redirect <= 1'b0;
            bus.exc_we      <= 1'b0;
            bus.badvaddr_we <= 1'b0;
            bus.eret_we     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_type    <= bus.except_type[3:0];
                        r_pc      <= bus.pc_m;
                        r_bad     <= bus.bad_addr_m;
                        r_bd      <= bus.in_delayslot_m;
                        r_cp0_epc <= bus.cp0_epc;
                        r_state   <= bus.stall_m ? S_WAIT : S_COMMIT;
                        bus.busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!bus.stall_m) r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_state <= S_HOLD;
                    r_cnt   <= HOLD_LOAD;
                end
                default: begin
                    if (r_cnt == 3'd0) begin
                        r_state  <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
            endcase

            if (w_commit_go) begin
                bus.flush       <= 1'b1;
                bus.pc_redirect <= 1'b1;
                if (w_eret) begin
                    bus.eret_we <= 1'b1;
                    bus.new_pc  <= w_cp0_epc;
                end else begin
                    bus.exc_we      <= 1'b1;
                    bus.new_pc      <= EXC_VECTOR;
                    bus.exc_code    <= w_code;
                    bus.exc_bd      <= w_bd;
                    bus.exc_epc     <= w_epc_val;
                    bus.badvaddr_we <= w_bv_we;
                    if (w_bv_we) bus.exc_badvaddr <= w_bv;
                end
            end
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: stimulus pushes expected commits, a negedge
// monitor pops and compares whenever flush is seen.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct {
        int          cyc;
        logic        eret;
        logic [31:0] new_pc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic        bv_we;
        logic [31:0] bv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];

    exc_ctrl_if bus ();

    exc_ctrl #(.EXC_VECTOR(VEC), .HOLD_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] t, input logic [31:0] pc, input logic [31:0] bad,
                         input logic bd, input logic [31:0] cepc, input logic stall);
        bus.except_type    = t;
        bus.pc_m           = pc;
        bus.bad_addr_m     = bad;
        bus.in_delayslot_m = bd;
        bus.cp0_epc        = cepc;
        bus.stall_m        = stall;
    endtask

    task automatic expect_commit(input int c, input logic eret, input logic [31:0] npc,
                                 input logic [4:0] code, input logic bd, input logic [31:0] epc,
                                 input logic bv_we, input logic [31:0] bv);
        exp_t e;
        e.cyc = c; e.eret = eret; e.new_pc = npc; e.code = code;
        e.bd = bd; e.epc = epc; e.bv_we = bv_we; e.bv = bv;
        q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flush"},   32'(bus.flush), 0);
        chk({tag, "_redir"},   32'(bus.pc_redirect), 0);
        chk({tag, "_new_pc"},  bus.new_pc, 0);
        chk({tag, "_exc_we"},  32'(bus.exc_we), 0);
        chk({tag, "_code"},    32'(bus.exc_code), 0);
        chk({tag, "_bd"},      32'(bus.exc_bd), 0);
        chk({tag, "_epc"},     bus.exc_epc, 0);
        chk({tag, "_bv_we"},   32'(bus.badvaddr_we), 0);
        chk({tag, "_bv"},      bus.exc_badvaddr, 0);
        chk({tag, "_eret_we"}, 32'(bus.eret_we), 0);
        chk({tag, "_busy"},    32'(bus.busy), 0);
    endtask

    // Monitor: every flush must match the head of the scoreboard at the expected cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            n_assert++;
            if (!bus.flush && (bus.pc_redirect || bus.exc_we || bus.badvaddr_we || bus.eret_we)) begin
                n_fail++;
                $display("FAIL stray_strobe cyc=%0d redir=%b exc_we=%b bv_we=%b eret_we=%b expected all 0",
                         cyc, bus.pc_redirect, bus.exc_we, bus.badvaddr_we, bus.eret_we);
            end
            if (bus.flush) begin
                if (q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_commit cyc=%0d actual flush=1 expected 0", cyc);
                end else begin
                    e = q.pop_front();
                    chk("commit_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pc_redirect", 32'(bus.pc_redirect), 1);
                    chk("new_pc", bus.new_pc, e.new_pc);
                    chk("eret_we", 32'(bus.eret_we), 32'(e.eret));
                    chk("exc_we", 32'(bus.exc_we), 32'(!e.eret));
                    chk("badvaddr_we", 32'(bus.badvaddr_we), 32'(e.bv_we));
                    if (!e.eret) begin
                        chk("exc_code", 32'(bus.exc_code), 32'(e.code));
                        chk("exc_bd", 32'(bus.exc_bd), 32'(e.bd));
                        chk("exc_epc", bus.exc_epc, e.epc);
                    end
                    if (e.bv_we) chk("exc_badvaddr", bus.exc_badvaddr, e.bv);
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                n_assert++;
                n_fail++;
                $display("FAIL missed_commit cyc=%0d expected commit at cyc=%0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int n;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk_all_zero("reset");
        rst = 0;
        step();

        // Ov, plain
        drive(32'hc, 32'h80001000, 32'h0, 0, 32'h0, 0);
        expect_commit(cyc + 1, 0, VEC, 5'd12, 0, 32'h80001000, 0, 0);
        step(); bus.except_type = 0; repeat (4) step();

        // AdES in delay slot
        drive(32'h5, 32'h80001008, 32'h80002003, 1, 32'h0, 0);
        expect_commit(cyc + 1, 0, VEC, 5'd5, 1, 32'h80001004, 1, 32'h80002003);
        step(); bus.except_type = 0; repeat (4) step();

        // AdEL, fetch misaligned
        drive(32'h4, 32'h80000402, 32'h80003000, 0, 32'h0, 0);
        expect_commit(cyc + 1, 0, VEC, 5'd4, 0, 32'h80000402, 1, 32'h80000402);
        step(); bus.except_type = 0; repeat (4) step();

        // AdEL, data address
        drive(32'h4, 32'h80000400, 32'h80003000, 0, 32'h0, 0);
        expect_commit(cyc + 1, 0, VEC, 5'd4, 0, 32'h80000400, 1, 32'h80003000);
        step(); bus.except_type = 0; repeat (4) step();

        // ERET
        drive(32'he, 32'h80005000, 32'h0, 0, 32'h80001234, 0);
        expect_commit(cyc + 1, 1, 32'h80001234, 5'd0, 0, 32'h0, 0, 0);
        step(); bus.except_type = 0; repeat (4) step();

        // Bp in delay slot at pc 0: EPC wraps
        drive(32'h9, 32'h0, 32'h0, 1, 32'h0, 0);
        expect_commit(cyc + 1, 0, VEC, 5'd9, 1, 32'hFFFFFFFC, 0, 0);
        step(); bus.except_type = 0; repeat (4) step();

        // Unknown nonzero code is ignored
        drive(32'h3, 32'h80004000, 32'h0, 0, 32'h0, 0);
        step(); bus.except_type = 0;
        chk("ignored_busy", 32'(bus.busy), 0);
        repeat (3) step();

        // Sys with 3-cycle stall; inputs morph to ERET while waiting
        n = cyc;
        drive(32'h8, 32'h80006000, 32'h0, 0, 32'h0, 1);
        expect_commit(n + 4, 0, VEC, 5'd8, 0, 32'h80006000, 0, 0);
        step(); chk("wait_busy1", 32'(bus.busy), 1);
        drive(32'he, 32'h80007000, 32'h0, 1, 32'h80009999, 1);
        step(); chk("wait_busy2", 32'(bus.busy), 1);
        step(); chk("wait_busy3", 32'(bus.busy), 1);
        bus.stall_m = 0;
        step(); chk("commit_busy", 32'(bus.busy), 1);
        bus.except_type = 0;
        step(); chk("hold_busy1", 32'(bus.busy), 1);
        step(); chk("hold_busy2", 32'(bus.busy), 1);
        step(); chk("idle_busy", 32'(bus.busy), 0);
        repeat (2) step();

        // Reset while in WAIT
        drive(32'h4, 32'h80000404, 32'h80000111, 0, 32'h0, 1);
        step(); chk("rstwait_busy", 32'(bus.busy), 1);
        rst = 1;
        step();
        rst = 0; bus.except_type = 0; bus.stall_m = 0;
        chk_all_zero("rst_in_wait");
        repeat (3) step();

        // Int, then Bp held: second commit HOLD_CYCLES+2 later
        n = cyc;
        drive(32'h1, 32'h80008000, 32'h0, 0, 32'h0, 0);
        expect_commit(n + 1, 0, VEC, 5'd0, 0, 32'h80008000, 0, 0);
        step();
        bus.except_type = 32'h9; bus.pc_m = 32'h80008100;
        expect_commit(n + 5, 0, VEC, 5'd9, 0, 32'h80008100, 0, 0);
        repeat (4) step();
        bus.except_type = 0;
        repeat (6) step();

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception commit controller for the MIPS pipeline: it takes the prioritised exception code produced in the MEM stage and sequences the precise-exception response. It captures the faulting instruction's context and waits out any outstanding memory stall. It then issues a single-cycle commit (CP0 writes, pipeline flush, PC redirect) and holds off new exceptions while the refetch settles. It sits between the MEM-stage exception encoder, CP0, the hazard unit and the PC mux.

## Interface
- EXC_VECTOR, 32'hBFC00380: redirect target for all exceptions except ERET.
- HOLD_CYCLES, 2: cycles after commit during which `except_type` is ignored (range 1–7).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- except_type  in  32  MEM-stage code: 0 none, 1 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, e ERET; any other nonzero value is treated as none.
- pc_m  in  32  PC of the MEM-stage instruction.
- bad_addr_m  in  32  data address of the MEM-stage load/store.
- in_delayslot_m  in  1  MEM-stage instruction is in a branch delay slot.
- stall_m  in  1  MEM stage stalled (memory access outstanding).
- cp0_epc  in  32  current EPC value.
- flush  out  1  flush all stages IF..MEM (1-cycle pulse).
- pc_redirect  out  1  load `new_pc` into the PC (1-cycle pulse, coincident with `flush`).
- new_pc  out  32  redirect target.
- exc_we  out  1  write Cause.ExcCode/BD and EPC, set Status.EXL.
- exc_code  out  5  Cause.ExcCode value.
- exc_bd  out  1  Cause.BD value.
- exc_epc  out  32  EPC value.
- badvaddr_we  out  1  write BadVAddr.
- exc_badvaddr  out  32  BadVAddr value.
- eret_we  out  1  clear Status.EXL.
- busy  out  1  controller not in IDLE; the hazard unit freezes IF/ID while high.

## Operation
- States: IDLE, WAIT, COMMIT, HOLD.
- IDLE: on a valid nonzero `except_type`, capture the type, `pc_m`, `bad_addr_m`, `in_delayslot_m` and `cp0_epc`. Go to COMMIT if `stall_m`=0, otherwise to WAIT.
- WAIT: captured values are frozen and inputs are ignored. Go to COMMIT on the first cycle with `stall_m`=0.
- COMMIT: lasts exactly one cycle, with all outputs driven from captured values. Then go to HOLD with the counter loaded to HOLD_CYCLES−1.
- HOLD: `except_type` is ignored. Decrement the counter; at 0, go to IDLE.
- Code mapping (`exc_code`): 1→0, 4→4, 5→5, 8→8, 9→9, a→10, c→12.
- Non-ERET commit:
  - `exc_we`=1, `flush`=1, `pc_redirect`=1, `new_pc`=EXC_VECTOR.
  - `exc_bd`=captured delay-slot flag.
  - `exc_epc`=pc−4 (32-bit wrap) if in delay slot, else pc.
- BadVAddr on commit:
  - AdEL with pc[1:0]≠0 (fetch error): `badvaddr_we`=1, `exc_badvaddr`=pc.
  - AdEL with pc[1:0]=0: `badvaddr_we`=1, `exc_badvaddr`=bad_addr.
  - AdES: `badvaddr_we`=1, `exc_badvaddr`=bad_addr.
  - All other types: `badvaddr_we`=0.
- ERET commit: `eret_we`=1, `flush`=1, `pc_redirect`=1, `new_pc`=captured `cp0_epc`, `exc_we`=0, `badvaddr_we`=0.
- `busy`=1 in WAIT, COMMIT and HOLD.

## Timing
- Reset: state IDLE; all outputs 0, including `new_pc`, `exc_*` and `busy`; captured registers cleared. Reset in any state aborts the operation with no commit pulse.
- Latency: exception valid at edge T with `stall_m`=0 → COMMIT outputs high during cycle T+1 only.
- With a stall: COMMIT occurs in the cycle after the first edge that samples `stall_m`=0 in WAIT.
- All strobes (`flush`, `pc_redirect`, `exc_we`, `badvaddr_we`, `eret_we`) are registered, high for exactly one cycle, and 0 outside COMMIT.
- Data outputs hold their last committed value outside COMMIT.
- An exception arriving in WAIT, COMMIT or HOLD is dropped. An exception arriving on the cycle HOLD exits (counter=0) is also dropped; the earliest accept is the first IDLE cycle.
- Back-to-back: minimum spacing between commits is HOLD_CYCLES+2 cycles.

## Test plan
- Ov at pc_m=0x80001000, not delay slot, no stall → cycle T+1: `exc_code`=12, `exc_epc`=0x80001000, `exc_bd`=0, `new_pc`=0xBFC00380, single `flush` pulse.
- AdES, bad_addr_m=0x80002003, in delay slot, pc_m=0x80001008 → `exc_epc`=0x80001004, `exc_bd`=1, `badvaddr_we`=1, `exc_badvaddr`=0x80002003.
- AdEL with pc_m=0x80000402 → `exc_badvaddr`=0x80000402. ERET with cp0_epc=0x80001234 → `new_pc`=0x80001234, `eret_we`=1, `exc_we`=0.
- Sys with `stall_m` high for 3 cycles; inputs changed to ERET during WAIT → commit one cycle after the stall drops, `exc_code`=8, `busy` high throughout.
- Int commit, then `except_type`=9 held continuously → second commit exactly HOLD_CYCLES+2 cycles after the first.
- `rst` asserted in WAIT → next cycle IDLE, no commit strobe, all outputs 0.
